button_conditioner: RTL

//   Cleans up the two raw push-button inputs that drive the 4-bit counter stage.

---
 rtl/button_conditioner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Synchronises and debounces the step and mode push-buttons. Step gives one pulse per
// press plus auto-repeat while held; mode toggles a level on each press.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 50000,
  parameter int REPEAT_CYCLES   = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic step_btn_in,
  input  logic mode_btn_in,
  output logic step_pulse,
  output logic step_held,
  output logic mode_sel
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_REPEAT   = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_deb;
  logic [1:0] r_deb_d;
  logic       w_step_rise;
  logic       w_step_fall;
  logic       w_mode_rise;

  state_t     r_state;
  logic [RW-1:0] r_rcnt;
  logic       r_step_pulse;
  logic       r_mode_sel;

  assign w_raw = {mode_btn_in, step_btn_in};

  // Channel 0 = step, channel 1 = mode; identical synchroniser + debouncer each.
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [DW-1:0]          r_cnt;
      logic                   r_deb;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
          r_cnt  <= '0;
          r_deb  <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
          if (r_sync[SYNC_STAGES-1] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_deb <= ~r_deb;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
      end

      assign w_deb[g] = r_deb;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_d <= 2'b00;
    end else begin
      r_deb_d <= w_deb;
    end
  end

  assign w_step_rise = w_deb[0] & ~r_deb_d[0];
  assign w_step_fall = ~w_deb[0] & r_deb_d[0];
  assign w_mode_rise = w_deb[1] & ~r_deb_d[1];

  // Step FSM and mode toggle; a debounced fall beats any same-cycle repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rcnt       <= '0;
      r_step_pulse <= 1'b0;
      r_mode_sel   <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      if (w_mode_rise) begin
        r_mode_sel <= ~r_mode_sel;
      end
      if (w_step_fall) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_step_rise) begin
              r_step_pulse <= 1'b1;
              r_rcnt       <= '0;
              if (HOLD_CYCLES == 0) begin
                r_state <= S_WAIT_REL;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (r_rcnt == HOLD_LAST) begin
              r_step_pulse <= 1'b1;
              r_rcnt       <= '0;
              r_state      <= S_REPEAT;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          S_REPEAT: begin
            if (r_rcnt == REP_LAST) begin
              r_step_pulse <= 1'b1;
              r_rcnt       <= '0;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          S_WAIT_REL: begin
            r_state <= S_WAIT_REL;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign step_pulse = r_step_pulse;
  assign step_held  = w_deb[0];
  assign mode_sel   = r_mode_sel;

endmodule
